gmii_tx_framer: RTL and testbench

Core-side GMII transmit framer in the `i_clk` (125 MHz) domain. It takes byte-stream frames from the switch output path over a valid/ready handshake and produces GMII transmit signals: preamble/SFD insertion, minimum-length padding, optional FCS generation and inter-frame gap enforcement. It is the transmit counterpart of the per-port GMII receive path and sits between the output queue and the port GMII adapter.

---
 rtl/gmii_tx_framer.sv | 171 +++++++++++++++++
 tb/tb_gmii_tx_framer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gmii_tx_framer.sv
// rtl/gmii_tx_framer.sv - GMII transmit framer: preamble/SFD, IFG, optional padding and CRC-32 FCS
// Macro GMII_TX_FCS_GEN_EN enables the PAD/FCS states; without it frames go out verbatim.
module gmii_tx_framer #(
  parameter int PREAMBLE_LEN = 7,
`ifdef GMII_TX_FCS_GEN_EN
  parameter int MIN_PAYLOAD  = 60,
`endif
  parameter int IFG_CYCLES   = 12
) (
  input  logic        i_clk,
  input  logic        w_core_rst_n,
  input  logic [7:0]  iv_data,
  input  logic        i_data_valid,
  input  logic        i_data_last,
  output logic        o_data_ready,
  output logic [7:0]  ov_gmii_txd,
  output logic        o_gmii_tx_en,
  output logic        o_gmii_tx_er,
  output logic        o_tx_busy,
  output logic [15:0] ov_tx_pkt_cnt,
  output logic [15:0] ov_underrun_cnt
);

  typedef enum logic [3:0] {
    S_IDLE, S_PREAMBLE, S_SFD, S_DATA, S_PAD, S_FCS, S_ABORT, S_DROP, S_IFG
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        last_acc_q, last_acc_d;
  logic [15:0] pkt_cnt_q, pkt_cnt_d;
  logic [15:0] und_cnt_q, und_cnt_d;
  logic [7:0]  txd_q, txd_d;
  logic        tx_en_q, tx_en_d;
  logic        tx_er_q, tx_er_d;
  logic        xfer;

`ifdef GMII_TX_FCS_GEN_EN
  logic [10:0] byte_cnt_q, byte_cnt_d, byte_inc;
  logic [31:0] crc_q, crc_d, fcs_w;

  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] d);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++)
      c = (c[0] ^ d[i]) ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    return c;
  endfunction

  assign byte_inc = (byte_cnt_q == 11'h7FF) ? byte_cnt_q : byte_cnt_q + 11'd1;
  assign fcs_w    = ~crc_q;
`endif

  assign xfer = o_data_ready & i_data_valid;

  always_ff @(posedge i_clk or negedge w_core_rst_n) begin
    if (!w_core_rst_n) state_q <= S_IDLE;
    else               state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (i_data_valid) state_d = S_PREAMBLE;
      S_PREAMBLE: if (cnt_q == 8'(PREAMBLE_LEN - 1)) state_d = S_SFD;
      S_SFD:      state_d = S_DATA;
      S_DATA: begin
        if (!i_data_valid) state_d = S_ABORT;
`ifdef GMII_TX_FCS_GEN_EN
        else if (i_data_last) state_d = (byte_inc < 11'(MIN_PAYLOAD)) ? S_PAD : S_FCS;
`else
        else if (i_data_last) state_d = S_IFG;
`endif
      end
`ifdef GMII_TX_FCS_GEN_EN
      S_PAD:      if (byte_inc >= 11'(MIN_PAYLOAD)) state_d = S_FCS;
      S_FCS:      if (cnt_q == 8'd3) state_d = S_IFG;
`endif
      S_ABORT:    state_d = last_acc_q ? S_IFG : S_DROP;
      S_DROP:     if (i_data_valid && i_data_last) state_d = S_IFG;
      S_IFG:      if (cnt_q == 8'(IFG_CYCLES - 1)) state_d = i_data_valid ? S_PREAMBLE : S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // The abort symbol is loaded on the underrun cycle itself, so it reaches the
  // wire while the FSM sits in ABORT and tx_en stays contiguous up to it.
  always_comb begin
    txd_d        = 8'h00;
    tx_en_d      = 1'b0;
    tx_er_d      = 1'b0;
    o_data_ready = (state_q == S_DATA) || (state_q == S_DROP);
    o_tx_busy    = (state_q != S_IDLE);
    case (state_q)
      S_PREAMBLE: begin txd_d = 8'h55; tx_en_d = 1'b1; end
      S_SFD:      begin txd_d = 8'hD5; tx_en_d = 1'b1; end
      S_DATA: begin
        tx_en_d = 1'b1;
        if (i_data_valid) txd_d = iv_data;
        else              tx_er_d = 1'b1;
      end
`ifdef GMII_TX_FCS_GEN_EN
      S_PAD:      tx_en_d = 1'b1;
      S_FCS:      begin txd_d = fcs_w[{cnt_q[1:0], 3'b000} +: 8]; tx_en_d = 1'b1; end
`endif
      default: ;
    endcase
  end

  always_comb begin
    cnt_d      = (state_d != state_q) ? 8'd0 : cnt_q + 8'd1;
    last_acc_d = last_acc_q;
    pkt_cnt_d  = pkt_cnt_q;
    und_cnt_d  = und_cnt_q;
    if (state_q == S_SFD) last_acc_d = 1'b0;
    if (state_q == S_DATA && xfer && i_data_last) last_acc_d = 1'b1;
    if (state_q == S_ABORT) und_cnt_d = und_cnt_q + 16'd1;
`ifdef GMII_TX_FCS_GEN_EN
    byte_cnt_d = byte_cnt_q;
    crc_d      = crc_q;
    if (state_q == S_SFD) begin
      byte_cnt_d = 11'd0;
      crc_d      = 32'hFFFF_FFFF;
    end else if (state_q == S_DATA && xfer) begin
      byte_cnt_d = byte_inc;
      crc_d      = crc32_byte(crc_q, iv_data);
    end else if (state_q == S_PAD) begin
      byte_cnt_d = byte_inc;
      crc_d      = crc32_byte(crc_q, 8'h00);
    end
    if (state_q == S_FCS && cnt_q == 8'd3) pkt_cnt_d = pkt_cnt_q + 16'd1;
`else
    if (state_q == S_DATA && xfer && i_data_last) pkt_cnt_d = pkt_cnt_q + 16'd1;
`endif
  end

  always_ff @(posedge i_clk or negedge w_core_rst_n) begin
    if (!w_core_rst_n) begin
      cnt_q      <= 8'd0;
      last_acc_q <= 1'b0;
      pkt_cnt_q  <= 16'd0;
      und_cnt_q  <= 16'd0;
      txd_q      <= 8'h00;
      tx_en_q    <= 1'b0;
      tx_er_q    <= 1'b0;
`ifdef GMII_TX_FCS_GEN_EN
      byte_cnt_q <= 11'd0;
      crc_q      <= 32'hFFFF_FFFF;
`endif
    end else begin
      cnt_q      <= cnt_d;
      last_acc_q <= last_acc_d;
      pkt_cnt_q  <= pkt_cnt_d;
      und_cnt_q  <= und_cnt_d;
      txd_q      <= txd_d;
      tx_en_q    <= tx_en_d;
      tx_er_q    <= tx_er_d;
`ifdef GMII_TX_FCS_GEN_EN
      byte_cnt_q <= byte_cnt_d;
      crc_q      <= crc_d;
`endif
    end
  end

  assign ov_gmii_txd     = txd_q;
  assign o_gmii_tx_en    = tx_en_q;
  assign o_gmii_tx_er    = tx_er_q;
  assign ov_tx_pkt_cnt   = pkt_cnt_q;
  assign ov_underrun_cnt = und_cnt_q;

endmodule

// File: tb/tb_gmii_tx_framer.sv
// tb/tb_gmii_tx_framer.sv - scoreboard bench for gmii_tx_framer
// Expected wire symbols are queued per frame and popped by the wire monitor.
`timescale 1ns/1ps
module tb_gmii_tx_framer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  data;
  logic        valid, last;
  logic        ready, tx_en, tx_er, busy;
  logic [7:0]  txd;
  logic [15:0] pkt_cnt, und_cnt;

  always #4 clk = ~clk;

  gmii_tx_framer dut (
    .i_clk(clk), .w_core_rst_n(rst_n), .iv_data(data), .i_data_valid(valid),
    .i_data_last(last), .o_data_ready(ready), .ov_gmii_txd(txd), .o_gmii_tx_en(tx_en),
    .o_gmii_tx_er(tx_er), .o_tx_busy(busy), .ov_tx_pkt_cnt(pkt_cnt), .ov_underrun_cnt(und_cnt)
  );

  int         n_checks = 0;
  int         n_fail = 0;
  logic [8:0] exp_q[$];
  logic [7:0] cap_q[$];
  int         en_len_q[$];
  int         gap_q[$];
  logic [7:0] frame [0:255];

  int   en_run = 0;
  int   low_run = 0;
  logic prev_en = 1'b0;
  logic seen_frame = 1'b0;

  initial begin
    logic [8:0] e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        en_run = 0; low_run = 0; prev_en = 1'b0; seen_frame = 1'b0;
      end else begin
        if (tx_en) begin
          if (!prev_en) begin
            if (seen_frame) gap_q.push_back(low_run);
            cap_q.delete();
            en_run = 0;
          end
          en_run++;
          cap_q.push_back(txd);
          n_checks++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL wire_byte: got er=%0b txd=%02h, expected no transmission", tx_er, txd);
          end else begin
            e = exp_q.pop_front();
            if ({tx_er, txd} !== e) begin
              n_fail++;
              $display("FAIL wire_byte: got er=%0b txd=%02h, expected er=%0b txd=%02h",
                       tx_er, txd, e[8], e[7:0]);
            end
          end
        end else begin
          if (prev_en) begin
            en_len_q.push_back(en_run);
            seen_frame = 1'b1;
            low_run = 0;
          end
          low_run++;
        end
        prev_en = tx_en;
      end
    end
  end

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int k = 0; k < 8; k++)
      r = (r[0] ^ d[k]) ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    return r;
  endfunction

  function automatic int exp_len(input int n);
`ifdef GMII_TX_FCS_GEN_EN
    return 8 + ((n < 60) ? 60 : n) + 4;
`else
    return 8 + n;
`endif
  endfunction

  task automatic fill_frame(input int base, input int n);
    for (int i = 0; i < n; i++) frame[base + i] = 8'($urandom);
  endtask

  task automatic push_preamble();
    for (int i = 0; i < 7; i++) exp_q.push_back({1'b0, 8'h55});
    exp_q.push_back({1'b0, 8'hD5});
  endtask

  task automatic push_frame(input int base, input int n);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    push_preamble();
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({1'b0, frame[base + i]});
      c = crc_byte(c, frame[base + i]);
    end
`ifdef GMII_TX_FCS_GEN_EN
    for (int i = n; i < 60; i++) begin
      exp_q.push_back(9'h000);
      c = crc_byte(c, 8'h00);
    end
    c = ~c;
    for (int k = 0; k < 4; k++) exp_q.push_back({1'b0, c[8*k +: 8]});
`else
    c = ~c;
`endif
  endtask

  // Called just after a negedge; returns just after a negedge.
  task automatic send_frame(input int base, input int n, input int gap_at, input int stop_after,
                            input bit hold, output int sent);
    int   i = 0;
    int   guard = 0;
    logic gapped = 1'b0;
    logic took;
    while (i < n && i != stop_after && guard < 5000) begin
      if (i == gap_at && !gapped) begin
        valid = 1'b0; last = 1'b0; gapped = 1'b1; took = 1'b0;
      end else begin
        valid = 1'b1; data = frame[base + i]; last = (i == n - 1); took = ready;
      end
      @(negedge clk);
      guard++;
      if (took) i++;
    end
    if (!hold) begin valid = 1'b0; last = 1'b0; end
    sent = i;
  endtask

  task automatic wait_idle();
    int guard = 0;
    while (busy && guard < 1000) begin @(negedge clk); guard++; end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_timeout: busy=%0b required 0", busy); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; valid = 1'b0; last = 1'b0; data = 8'h00;
    repeat (3) @(negedge clk);
    n_checks += 7;
    if (txd !== 8'h00)     begin n_fail++; $display("FAIL rst_txd: got %02h required 00", txd); end
    if (tx_en !== 1'b0)    begin n_fail++; $display("FAIL rst_tx_en: got %0b required 0", tx_en); end
    if (tx_er !== 1'b0)    begin n_fail++; $display("FAIL rst_tx_er: got %0b required 0", tx_er); end
    if (ready !== 1'b0)    begin n_fail++; $display("FAIL rst_ready: got %0b required 0", ready); end
    if (busy !== 1'b0)     begin n_fail++; $display("FAIL rst_busy: got %0b required 0", busy); end
    if (pkt_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_pkt_cnt: got %0d required 0", pkt_cnt); end
    if (und_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_und_cnt: got %0d required 0", und_cnt); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_underrun();
    int sent;
    fill_frame(0, 100);
    push_preamble();
    for (int i = 0; i < 20; i++) exp_q.push_back({1'b0, frame[i]});
    exp_q.push_back({1'b1, 8'h00});
    en_len_q.delete();
    send_frame(0, 100, 20, -1, 1'b0, sent);
    wait_idle();
    n_checks += 5;
    if (sent !== 100) begin n_fail++; $display("FAIL und_drained: got %0d bytes required 100", sent); end
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL und_sb_left: got %0d required 0", exp_q.size()); end
    if (en_len_q.size() != 1 || en_len_q[0] != 29) begin
      n_fail++; $display("FAIL und_en_len: got %0d runs first %0d required 1 run of 29",
                         en_len_q.size(), (en_len_q.size() > 0) ? en_len_q[0] : -1);
    end
    if (und_cnt !== 16'd1) begin n_fail++; $display("FAIL und_cnt: got %0d required 1", und_cnt); end
    if (pkt_cnt !== 16'd0) begin n_fail++; $display("FAIL und_pkt_cnt: got %0d required 0", pkt_cnt); end
  endtask

  task automatic test_frame(input int n, input logic [15:0] pkt_exp);
    int sent;
    fill_frame(0, n);
    push_frame(0, n);
    en_len_q.delete();
    send_frame(0, n, -1, -1, 1'b0, sent);
    wait_idle();
    n_checks += 4;
    if (sent !== n) begin n_fail++; $display("FAIL frm%0d_sent: got %0d required %0d", n, sent, n); end
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL frm%0d_sb_left: got %0d required 0", n, exp_q.size()); end
    if (en_len_q.size() != 1 || en_len_q[0] != exp_len(n)) begin
      n_fail++; $display("FAIL frm%0d_en_len: got %0d runs first %0d required %0d", n, en_len_q.size(),
                         (en_len_q.size() > 0) ? en_len_q[0] : -1, exp_len(n));
    end
    if (pkt_cnt !== pkt_exp) begin n_fail++; $display("FAIL frm%0d_pkt_cnt: got %0d required %0d", n, pkt_cnt, pkt_exp); end
`ifdef GMII_TX_FCS_GEN_EN
    begin
      logic [31:0] c;
      c = 32'hFFFF_FFFF;
      for (int i = 8; i < cap_q.size(); i++) c = crc_byte(c, cap_q[i]);
      n_checks++;
      if (c !== 32'hDEBB_20E3) begin n_fail++; $display("FAIL frm%0d_residue: got %08h required DEBB20E3", n, c); end
    end
`endif
  endtask

  task automatic test_back_to_back();
    int s1, s2;
    logic [15:0] pkt0;
    pkt0 = pkt_cnt;
    fill_frame(0, 64);
    fill_frame(128, 64);
    push_frame(0, 64);
    push_frame(128, 64);
    en_len_q.delete();
    gap_q.delete();
    send_frame(0, 64, -1, -1, 1'b1, s1);
    send_frame(128, 64, -1, -1, 1'b0, s2);
    wait_idle();
    n_checks += 5;
    if (s1 !== 64 || s2 !== 64) begin n_fail++; $display("FAIL b2b_sent: got %0d/%0d required 64/64", s1, s2); end
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL b2b_sb_left: got %0d required 0", exp_q.size()); end
    if (en_len_q.size() != 2 || en_len_q[0] != exp_len(64) || en_len_q[1] != exp_len(64)) begin
      n_fail++; $display("FAIL b2b_en_len: got %0d runs required 2 runs of %0d", en_len_q.size(), exp_len(64));
    end
    if (gap_q.size() == 0 || gap_q[gap_q.size() - 1] != 12) begin
      n_fail++; $display("FAIL b2b_gap: got %0d required 12",
                         (gap_q.size() > 0) ? gap_q[gap_q.size() - 1] : -1);
    end
    if (pkt_cnt !== pkt0 + 16'd2) begin n_fail++; $display("FAIL b2b_pkt_cnt: got %0d required %0d", pkt_cnt, pkt0 + 16'd2); end
  endtask

  task automatic test_reset_midframe();
    int sent;
    fill_frame(0, 64);
    push_frame(0, 64);
    send_frame(0, 64, -1, 30, 1'b1, sent);
    #2 rst_n = 1'b0;
    #1;
    n_checks += 7;
    if (sent !== 30)       begin n_fail++; $display("FAIL mid_sent: got %0d required 30", sent); end
    if (txd !== 8'h00)     begin n_fail++; $display("FAIL mid_txd: got %02h required 00", txd); end
    if (tx_en !== 1'b0)    begin n_fail++; $display("FAIL mid_tx_en: got %0b required 0", tx_en); end
    if (tx_er !== 1'b0)    begin n_fail++; $display("FAIL mid_tx_er: got %0b required 0", tx_er); end
    if (ready !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL mid_ready_busy: got %0b/%0b required 0/0", ready, busy);
    end
    if (pkt_cnt !== 16'd0) begin n_fail++; $display("FAIL mid_pkt_cnt: got %0d required 0", pkt_cnt); end
    if (und_cnt !== 16'd0) begin n_fail++; $display("FAIL mid_und_cnt: got %0d required 0", und_cnt); end
    exp_q.delete();
    valid = 1'b0; last = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_frame(64, 16'd1);
    n_checks++;
    if (und_cnt !== 16'd0) begin n_fail++; $display("FAIL mid_und_after: got %0d required 0", und_cnt); end
  endtask

  initial begin
    test_reset();
    test_underrun();
`ifdef GMII_TX_FCS_GEN_EN
    test_frame(64, 16'd1);
    test_frame(10, 16'd2);
`else
    test_frame(20, 16'd1);
    test_frame(64, 16'd2);
`endif
    test_back_to_back();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
